// File: rtl/mod7_serializer_if.sv
// Handshake and serial-output bundle between a word source and the mod-7 serializer.
// The source side uses the master modport; the serializer uses the slave modport.
interface mod7_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_clr;
    logic             ser_bit;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  ser_clr,
        input  ser_bit,
        input  ser_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output ser_clr,
        output ser_bit,
        output ser_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/mod7_serializer.sv
// Parallel-to-serial feeder for the mod-7 remainder stage: clear strobe, MSB-first bits,
// then a done pulse. All outputs are registered; synchronous active-high reset.
module mod7_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    mod7_serializer_if.slave   bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StShift,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CntW-1:0]  cnt_q;
    logic             in_ready_q;
    logic             ser_clr_q;
    logic             ser_bit_q;
    logic             ser_valid_q;
    logic             busy_q;
    logic             done_q;

    // Accept only once in_ready is actually visible, so the cycle right after
    // reset (in_ready still 0) can never take a word.
    logic accept;
    assign accept = (state_q == StIdle) && in_ready_q && bus.in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            shreg_q     <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            ser_clr_q   <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ser_clr_q   <= 1'b0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (accept) begin
                        shreg_q    <= bus.in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        ser_clr_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= StClear;
                    end
                end
                StClear: begin
                    // Present the MSB now so bit 0 appears the cycle after the clear.
                    ser_valid_q <= 1'b1;
                    ser_bit_q   <= shreg_q[WIDTH-1];
                    shreg_q     <= shreg_q << 1;
                    cnt_q       <= '0;
                    state_q     <= StShift;
                end
                StShift: begin
                    if (cnt_q == LastCnt) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        ser_valid_q <= 1'b1;
                        ser_bit_q   <= shreg_q[WIDTH-1];
                        shreg_q     <= shreg_q << 1;
                        cnt_q       <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    in_ready_q <= 1'b1;
                    cnt_q      <= '0;
                    state_q    <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.ser_clr   = ser_clr_q;
    assign bus.ser_bit   = ser_bit_q & ser_valid_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_mod7_serializer.sv
// Directed bench for mod7_serializer (WIDTH 8 and 16) with a bit/remainder scoreboard
// fed on accept and drained by negedge monitors that model the downstream mod-7 stage.
module tb_mod7_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mod7_serializer_if #(.WIDTH(8))  bus8 ();
    mod7_serializer_if #(.WIDTH(16)) bus16 ();

    mod7_serializer #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    mod7_serializer #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboards: expected bits and remainders pushed when a word is accepted.
    bit exp_bits8[$];
    int exp_rem8[$];
    int acc_log8[$];
    int acc8 = -100, k8 = 0, rem8 = 0, done_cnt8 = 0;
    bit exp_bits16[$];
    int exp_rem16[$];
    int acc16 = -100, k16 = 0, rem16 = 0, done_cnt16 = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus8.ser_clr === 1'b1) begin
                check("clr8_time", cyc, acc8 + 1);
                rem8 = 0;
                k8 = 0;
            end
            if (bus8.ser_valid === 1'b1) begin
                check("bit8_time", cyc, acc8 + 2 + k8);
                check("bit8_pending", exp_bits8.size() > 0, 1);
                if (exp_bits8.size() > 0) check("bit8_val", bus8.ser_bit, exp_bits8.pop_front());
                rem8 = (rem8 * 2 + int'(bus8.ser_bit)) % 7;
                k8++;
            end else begin
                check("bit8_idle_zero", bus8.ser_bit, 0);
            end
            if (bus8.done === 1'b1) begin
                done_cnt8++;
                check("done8_time", cyc, acc8 + 10);
                check("done8_bits", k8, 8);
                check("rem8_pending", exp_rem8.size() > 0, 1);
                if (exp_rem8.size() > 0) check("rem8", rem8, exp_rem8.pop_front());
            end
            if (bus8.busy === 1'b1 || bus8.done === 1'b1) check("ready8_low", bus8.in_ready, 0);
            if (rst) begin
                exp_bits8.delete();
                exp_rem8.delete();
            end else if (bus8.in_valid === 1'b1 && bus8.in_ready === 1'b1) begin
                acc8 = cyc;
                acc_log8.push_back(cyc);
                for (int i = 7; i >= 0; i--) exp_bits8.push_back(bus8.in_data[i]);
                exp_rem8.push_back(int'(bus8.in_data) % 7);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus16.ser_clr === 1'b1) begin
                check("clr16_time", cyc, acc16 + 1);
                rem16 = 0;
                k16 = 0;
            end
            if (bus16.ser_valid === 1'b1) begin
                check("bit16_time", cyc, acc16 + 2 + k16);
                check("bit16_pending", exp_bits16.size() > 0, 1);
                if (exp_bits16.size() > 0)
                    check("bit16_val", bus16.ser_bit, exp_bits16.pop_front());
                rem16 = (rem16 * 2 + int'(bus16.ser_bit)) % 7;
                k16++;
            end else begin
                check("bit16_idle_zero", bus16.ser_bit, 0);
            end
            if (bus16.done === 1'b1) begin
                done_cnt16++;
                check("done16_time", cyc, acc16 + 18);
                check("done16_bits", k16, 16);
                check("rem16_pending", exp_rem16.size() > 0, 1);
                if (exp_rem16.size() > 0) check("rem16", rem16, exp_rem16.pop_front());
            end
            if (rst) begin
                exp_bits16.delete();
                exp_rem16.delete();
            end else if (bus16.in_valid === 1'b1 && bus16.in_ready === 1'b1) begin
                acc16 = cyc;
                for (int i = 15; i >= 0; i--) exp_bits16.push_back(bus16.in_data[i]);
                exp_rem16.push_back(int'(bus16.in_data) % 7);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8();
        int t = 0;
        while (bus8.in_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        check("ready8_wait", bus8.in_ready, 1);
    endtask

    task automatic send8(input logic [7:0] w);
        bus8.in_valid = 1'b1;
        bus8.in_data  = w;
        wait_ready8();
        step();
        bus8.in_valid = 1'b0;
    endtask

    task automatic wait_done8(input int target);
        int t = 0;
        while (done_cnt8 < target && t < 60) begin
            step();
            t++;
        end
        check("done8_seen", done_cnt8 >= target, 1);
        step();
    endtask

    task automatic send16(input logic [15:0] w);
        int t = 0;
        bus16.in_valid = 1'b1;
        bus16.in_data  = w;
        while (bus16.in_ready !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        check("ready16_wait", bus16.in_ready, 1);
        step();
        bus16.in_valid = 1'b0;
    endtask

    task automatic wait_done16(input int target);
        int t = 0;
        while (done_cnt16 < target && t < 80) begin
            step();
            t++;
        end
        check("done16_seen", done_cnt16 >= target, 1);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int d;
        int n;
        bus8.in_valid  = 1'b0;
        bus8.in_data   = '0;
        bus16.in_valid = 1'b0;
        bus16.in_data  = '0;

        // Reset held three cycles: every output low.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            mon_en = 1'b1;
            check("rst_ready", bus8.in_ready, 0);
            check("rst_clr", bus8.ser_clr, 0);
            check("rst_valid", bus8.ser_valid, 0);
            check("rst_bit", bus8.ser_bit, 0);
            check("rst_busy", bus8.busy, 0);
            check("rst_done", bus8.done, 0);
            check("rst16_ready", bus16.in_ready, 0);
        end
        rst = 1'b0;
        step();
        check("post_rst_ready", bus8.in_ready, 1);
        check("post_rst_valid", bus8.ser_valid, 0);
        check("post_rst_ready16", bus16.in_ready, 1);

        // Single word.
        send8(8'h15);
        wait_done8(1);

        // Back-to-back with in_valid held high.
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'hFF;
        wait_ready8();
        step();
        bus8.in_data = 8'h64;
        wait_ready8();
        step();
        bus8.in_valid = 1'b0;
        wait_done8(3);
        n = acc_log8.size();
        check("b2b_period", acc_log8[n-1] - acc_log8[n-2], 11);

        // Abort during the fourth shift cycle of 8'hA5.
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'hA5;
        wait_ready8();
        step();
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("abort_pre_valid", bus8.ser_valid, 1);
        d = done_cnt8;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", bus8.ser_valid, 0);
        check("abort_busy", bus8.busy, 0);
        check("abort_done", bus8.done, 0);
        for (int i = 0; i < 12; i++) step();
        check("abort_no_done", done_cnt8, d);
        send8(8'h07);
        wait_done8(d + 1);

        // Reset and in_valid together: no word accepted.
        d = done_cnt8;
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h55;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus8.in_valid = 1'b0;
        check("rstv_busy", bus8.busy, 0);
        check("rstv_clr", bus8.ser_clr, 0);
        step();
        check("rstv_ready", bus8.in_ready, 1);
        check("rstv_busy2", bus8.busy, 0);

        // Inputs toggle while busy; only the accepted word is serialized.
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h3C;
        wait_ready8();
        step();
        for (int i = 0; i < 9; i++) begin
            bus8.in_data  = 8'($urandom);
            bus8.in_valid = 1'($urandom_range(0, 1));
            check("busy_ready_low", bus8.in_ready, 0);
            step();
        end
        bus8.in_valid = 1'b0;
        wait_done8(d + 1);

        // WIDTH=16 instance.
        send16(16'hFFFF);
        wait_done16(1);
        send16(16'h1234);
        wait_done16(2);

        check("sb8_empty", exp_bits8.size() + exp_rem8.size(), 0);
        check("sb16_empty", exp_bits16.size() + exp_rem16.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
